// File: rtl/col_inter_pkg.sv
// Shared types and constants for the vertical column interpolator.
// Q1.8 arithmetic: ONE is unity weight / one source line of phase advance.
package col_inter_pkg;
    typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

    localparam int LINE_W_DEF = 1280;
    localparam int ONE        = 256;
endpackage

// File: rtl/col_lerp.sv
// Weighted average of two vertically adjacent pixels: (a*(256-f) + b*f + 128) >> 8.
// Latency 2 cycles (products, then rounded sum); no backpressure, flush drops in-flight pixels.
module col_lerp
    import col_inter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       in_vld,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] f,
    output logic [7:0] out_data,
    output logic       out_en,
    output logic       pipe_busy
);
    logic [8:0]  wa;
    logic [16:0] pa_q;
    logic [16:0] pb_q;
    logic        s1_vld;
    logic [16:0] sum;

    assign wa        = 9'(ONE) - {1'b0, f};
    assign sum       = pa_q + pb_q + 17'd128;
    assign pipe_busy = s1_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pa_q     <= '0;
            pb_q     <= '0;
            s1_vld   <= 1'b0;
            out_data <= '0;
            out_en   <= 1'b0;
        end else begin
            s1_vld <= in_vld & ~flush;
            out_en <= s1_vld & ~flush;
            if (in_vld) begin
                pa_q <= 17'(a) * 17'(wa);
                pb_q <= 17'(b) * 17'(f);
            end
            if (s1_vld) begin
                out_data <= 8'(sum >> 8);
            end
        end
    end
endmodule

// File: rtl/col_inter.sv
// Vertical scaler: walks source lines with a Q1.8 phase, requesting new lines from the column buffer.
// Output 2 cycles after input pixel; no backpressure, a missed line request only raises sticky underrun.
module col_inter
    import col_inter_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int STEP_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic [10:0]       src_lines,
    input  logic [STEP_W-1:0] step,
    input  logic              in_en,
    input  logic [7:0]        buf1_data,
    input  logic [7:0]        buf2_data,
    output logic              line_req,
    output logic [7:0]        out_data,
    output logic              out_en,
    output logic              frame_done,
    output logic              underrun
);
    localparam int COL_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;

    state_t           state;
    state_t           state_nxt;
    logic [COL_W-1:0] col_cnt;
    logic             started;
    logic             win_in;
    logic [1:0]       fill_cnt;
    logic [7:0]       phase;
    logic [10:0]      loaded;
    logic [10:0]      src_lines_r;
    logic [8:0]       eff_step;
    logic             req_win;
    logic             lerp_vld;
    logic             pipe_busy;

    logic             active;
    logic [COL_W-1:0] col;
    logic             tick;
    logic             win_end;
    logic             win_hit;
    logic             fill_done;
    logic [8:0]       phase_sum;
    logic             carry;
    logic [10:0]      loaded_nxt;
    logic             last_win;
    logic             short_frame;
    logic [8:0]       step_in;

    // The window counter only starts on the first in_en after frame_start, then free-runs.
    assign active      = (state == FILL) || (state == RUN);
    assign col         = started ? col_cnt : '0;
    assign tick        = active && (started || in_en);
    assign win_end     = tick && (col == COL_W'(LINE_W - 1));
    assign win_hit     = (col == '0) ? in_en : win_in;
    assign fill_done   = (state == FILL) && win_end && win_hit && (fill_cnt == 2'd1);
    assign phase_sum   = {1'b0, phase} + eff_step;
    assign carry       = phase_sum[8];
    assign loaded_nxt  = loaded + {10'd0, req_win};
    assign last_win    = (state == RUN) && win_end && carry && (loaded_nxt >= src_lines_r);
    assign short_frame = (src_lines < 11'd2);

    always_comb begin
        step_in = 9'(step);
        if (step == '0 || 32'(step) > 32'(ONE)) begin
            step_in = 9'(ONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (frame_start) begin
            state_nxt = short_frame ? IDLE : FILL;
        end else begin
            case (state)
                IDLE: state_nxt = IDLE;
                FILL: if (fill_done) state_nxt = RUN;
                RUN:  if (last_win) state_nxt = DONE;
                DONE: if (!pipe_busy) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        line_req = 1'b0;
        lerp_vld = 1'b0;
        case (state)
            FILL: line_req = 1'b1;
            RUN: begin
                line_req = req_win;
                lerp_vld = 1'b1;
            end
            default: begin
                line_req = 1'b0;
                lerp_vld = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt     <= '0;
            started     <= 1'b0;
            win_in      <= 1'b0;
            fill_cnt    <= '0;
            phase       <= '0;
            loaded      <= '0;
            src_lines_r <= '0;
            eff_step    <= '0;
            req_win     <= 1'b0;
            frame_done  <= 1'b0;
            underrun    <= 1'b0;
        end else if (frame_start) begin
            col_cnt     <= '0;
            started     <= 1'b0;
            win_in      <= 1'b0;
            fill_cnt    <= '0;
            phase       <= '0;
            loaded      <= '0;
            req_win     <= 1'b0;
            src_lines_r <= src_lines;
            eff_step    <= step_in;
            frame_done  <= short_frame;
        end else begin
            frame_done <= (state == DONE) && !pipe_busy;
            if (tick) begin
                started <= 1'b1;
                col_cnt <= win_end ? '0 : col + 1'b1;
                if (col == '0) begin
                    win_in <= in_en;
                end
            end
            if (active && started && (col == '0) && line_req && !in_en) begin
                underrun <= 1'b1;
            end
            if ((state == FILL) && win_end && win_hit) begin
                fill_cnt <= fill_cnt + 2'd1;
                if (fill_done) begin
                    phase   <= '0;
                    loaded  <= 11'd2;
                    req_win <= 1'b0;
                end
            end
            // Phase stays below 2*ONE, so dropping bit 8 is the "-= 256" on carry.
            if ((state == RUN) && win_end) begin
                loaded  <= loaded_nxt;
                phase   <= phase_sum[7:0];
                req_win <= carry;
            end
        end
    end

    col_lerp u_lerp (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (frame_start),
        .in_vld    (lerp_vld),
        .a         (buf2_data),
        .b         (buf1_data),
        .f         (phase),
        .out_data  (out_data),
        .out_en    (out_en),
        .pipe_busy (pipe_busy)
    );
endmodule

// File: tb/tb_col_inter.sv
// Directed scoreboard bench for col_inter: upstream buffer model answers line_req,
// expected pixels are queued per frame and popped by an independent output monitor.
module tb_col_inter;
    localparam int LW = 640;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [10:0] src_lines = '0;
    logic [8:0]  step = '0;
    logic        in_en = 1'b0;
    logic [7:0]  buf1_data = '0;
    logic [7:0]  buf2_data = '0;
    logic        line_req;
    logic [7:0]  out_data;
    logic        out_en;
    logic        frame_done;
    logic        underrun;

    col_inter #(.LINE_W(LW), .STEP_W(9)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .src_lines   (src_lines),
        .step        (step),
        .in_en       (in_en),
        .buf1_data   (buf1_data),
        .buf2_data   (buf2_data),
        .line_req    (line_req),
        .out_data    (out_data),
        .out_en      (out_en),
        .frame_done  (frame_done),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame configuration handed to the driver
    int          start_tok = 0;
    logic [10:0] cfg_src = '0;
    logic [8:0]  cfg_step = '0;
    int          cfg_max = 0;
    bit          cfg_fixed = 1'b0;
    logic [7:0]  cfg_f1 = '0;
    logic [7:0]  cfg_f2 = '0;
    logic [7:0]  cfg_lines [0:7];

    // Upstream column-buffer model
    int         start_seen = 0;
    int         shift_left = 0;
    int         shifts_done = 0;
    int         shift1_cyc = 0;
    int         shift3_cyc = 0;
    int         fs_cyc = 0;
    logic [7:0] newer = '0;
    logic [7:0] older = '0;

    always @(negedge clk) begin
        if (start_seen != start_tok) begin
            start_seen  = start_tok;
            frame_start = 1'b1;
            src_lines   = cfg_src;
            step        = cfg_step;
            in_en       = 1'b0;
            shift_left  = 0;
            shifts_done = 0;
            fs_cyc      = cyc;
        end else begin
            frame_start = 1'b0;
            if (shift_left == 0 && line_req && shifts_done < cfg_max) begin
                shift_left = LW;
                shifts_done++;
                older = newer;
                newer = cfg_lines[shifts_done-1];
                if (shifts_done == 1) shift1_cyc = cyc;
                if (shifts_done == 3) shift3_cyc = cyc;
            end
            in_en = (shift_left > 0);
            if (shift_left > 0) shift_left--;
            buf1_data = cfg_fixed ? cfg_f1 : newer;
            buf2_data = cfg_fixed ? cfg_f2 : older;
        end
    end

    // Output monitor / scoreboard
    int done_cnt = 0;
    int last_oe_cyc = -10;
    always @(negedge clk) begin
        if (out_en) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out_en: out_data %0d with no pixel expected (cycle %0d)", out_data, cyc);
            end else begin
                check("pixel", out_data, exp_q.pop_front());
            end
            last_oe_cyc = cyc;
        end
        if (frame_done) begin
            done_cnt++;
            check("done_delay", cyc, (last_oe_cyc > fs_cyc) ? last_oe_cyc + 1 : fs_cyc + 1);
            check("queue_empty_at_done", exp_q.size(), 0);
        end
    end

    task automatic set_lines(input int a, input int b, input int c, input int d);
        for (int i = 0; i < 8; i++) cfg_lines[i] = '0;
        cfg_lines[0] = 8'(a);
        cfg_lines[1] = 8'(b);
        cfg_lines[2] = 8'(c);
        cfg_lines[3] = 8'(d);
    endtask

    task automatic start_frame(input int src, input int stp, input int maxs, input bit fixed,
                               input int f2, input int f1, input bit drop_q);
        cfg_src   = 11'(src);
        cfg_step  = 9'(stp);
        cfg_max   = maxs;
        cfg_fixed = fixed;
        cfg_f2    = 8'(f2);
        cfg_f1    = 8'(f1);
        start_tok++;
        @(posedge clk);
        #1;
        if (drop_q) exp_q.delete();
    endtask

    task automatic push_line(input int v);
        for (int i = 0; i < LW; i++) exp_q.push_back(8'(v));
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == d0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: frame_done not seen within %0d cycles", name, budget);
        end
        repeat (8) @(posedge clk);
        #1;
        check({name, "_done_once"}, done_cnt - d0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        set_lines(0, 0, 0, 0);
        #12;
        check("rst_out_en", out_en, 0);
        check("rst_out_data", out_data, 0);
        check("rst_line_req", line_req, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_underrun", underrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle_line_req", line_req, 0);

        // Step 256: f stays 0, each window shows the older line of its pair
        set_lines(10, 20, 30, 40);
        start_frame(4, 256, 8, 1'b0, 0, 0, 1'b0);
        check("fill_line_req", line_req, 1);
        push_line(10); push_line(20); push_line(30);
        wait_done(8 * LW, "step256");
        check("step256_shifts", shifts_done, 4);

        // Step 128: outputs alternate 0/100, a line every second window
        start_frame(3, 128, 8, 1'b1, 0, 200, 1'b0);
        push_line(0); push_line(100); push_line(0); push_line(100);
        wait_done(8 * LW, "step128");
        check("step128_shifts", shifts_done, 3);
        check("step128_req_spacing", shift3_cyc - shift1_cyc, 4 * LW);
        check("step128_underrun", underrun, 0);

        // Step 64: rounding of 100/101 blends
        start_frame(2, 64, 8, 1'b1, 100, 101, 1'b0);
        push_line(100); push_line(100); push_line(101); push_line(101);
        wait_done(8 * LW, "step64");
        check("step64_shifts", shifts_done, 2);

        // Fewer than two source lines: immediate frame_done, no pixels
        start_frame(1, 256, 8, 1'b1, 0, 0, 1'b0);
        wait_done(20, "src1");
        start_frame(0, 256, 8, 1'b1, 0, 0, 1'b0);
        wait_done(20, "src0");
        check("short_shifts", shifts_done, 0);

        // Upstream stops after FILL: underrun, output keeps flowing
        start_frame(4, 256, 2, 1'b1, 50, 150, 1'b0);
        push_line(50); push_line(50); push_line(50);
        repeat (2 * LW + LW / 2) @(posedge clk);
        #1;
        check("underrun_before", underrun, 0);
        wait_done(8 * LW, "underrun");
        check("underrun_set", underrun, 1);
        repeat (20) @(posedge clk);
        #1;
        check("underrun_sticky", underrun, 1);

        // Reset at RUN window 1, column 500
        set_lines(10, 20, 30, 40);
        start_frame(4, 256, 8, 1'b0, 0, 0, 1'b0);
        push_line(10); push_line(20); push_line(30);
        repeat (2 * LW + 500) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_out_en", out_en, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_line_req", line_req, 0);
        check("midrst_underrun", underrun, 0);
        @(negedge clk);
        check("midrst_frame_done", frame_done, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2 * LW) @(posedge clk);
        #1;
        check("postrst_line_req", line_req, 0);
        start_frame(2, 64, 8, 1'b1, 100, 101, 1'b0);
        check("postrst_fill", line_req, 1);
        push_line(100); push_line(100); push_line(101); push_line(101);
        wait_done(8 * LW, "postrst");

        // Abort mid-line, restart with step 0 (treated as 256)
        start_frame(3, 128, 8, 1'b1, 0, 200, 1'b0);
        push_line(0); push_line(100); push_line(0); push_line(100);
        repeat (3 * LW + 300) @(posedge clk);
        #1;
        start_frame(3, 0, 8, 1'b1, 40, 80, 1'b1);
        push_line(40); push_line(40);
        wait_done(8 * LW, "abort_step0");
        check("abort_shifts", shifts_done, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
